// File: rtl/fifo_flags_if.sv
// Handshake/data bundle between a producer/consumer and the fifo_flags FIFO.
// The master modport is the user side; the slave modport is the FIFO side.
interface fifo_flags_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             w_en;
    logic             r_en;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output w_en, r_en, din,
        input  dout, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  w_en, r_en, din,
        output dout, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_flags.sv
// Single-clock FIFO with fill count, almost-full/almost-empty thresholds and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is one-cycle registered read.
module fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fifo_flags_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          almost_full_q, almost_full_d;
    logic          almost_empty_q, almost_empty_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          w_acc, r_acc;
`ifndef FIFO_FWFT_EN
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             rd_valid_q, rd_valid_d;
`endif

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block infers a latch.
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
`ifndef FIFO_FWFT_EN
        dout_d         = dout_q;
        rd_valid_d     = 1'b0;
`endif

        // A pop frees a slot in the same edge, so a full FIFO can still take a write.
        r_acc = bus.r_en & ~empty_q;
        w_acc = bus.w_en & (~full_q | r_acc);

        if (w_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (r_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
`ifndef FIFO_FWFT_EN
            dout_d     = mem[rd_ptr_q];
            rd_valid_d = 1'b1;
`endif
        end

        case ({w_acc, r_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        full_d         = (count_d == DEPTH_C);
        empty_d        = (count_d == '0);
        almost_full_d  = (count_d >= AF_C);
        almost_empty_d = (count_d <= AE_C);
        overflow_d     = bus.w_en & ~w_acc;
        underflow_d    = bus.r_en & ~r_acc;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
`ifndef FIFO_FWFT_EN
            dout_q         <= '0;
            rd_valid_q     <= 1'b0;
`endif
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
`ifndef FIFO_FWFT_EN
            dout_q         <= dout_d;
            rd_valid_q     <= rd_valid_d;
`endif
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && w_acc) mem[wr_ptr_q] <= bus.din;
    end

`ifdef FIFO_FWFT_EN
    assign bus.dout     = mem[rd_ptr_q];
    assign bus.rd_valid = ~empty_q;
`else
    assign bus.dout     = dout_q;
    assign bus.rd_valid = rd_valid_q;
`endif
    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_flags.sv
// Directed bench for fifo_flags (standard read mode): queue-based model checked every
// cycle, plus literal expectations at the points of interest.
module tb_fifo_flags;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests  = 0;
    int   failed = 0;
    bit   chk_en = 1'b0;

    fifo_flags_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fifo_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of stored words plus the last-cycle read/error results.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout = '0;
    logic             m_rv = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_dout = '0;
            m_rv   = 1'b0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            bit can_rd, can_wr;
            can_rd = bus.r_en && (q.size() > 0);
            can_wr = bus.w_en && ((q.size() < DEPTH) || can_rd);
            m_ovf  = bus.w_en && !can_wr;
            m_udf  = bus.r_en && !can_rd;
            m_rv   = can_rd;
            if (can_rd) m_dout = q.pop_front();
            if (can_wr) q.push_back(bus.din);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_count", 32'(bus.count), 32'(q.size()));
            check("m_full", 32'(bus.full), 32'(q.size() == DEPTH));
            check("m_empty", 32'(bus.empty), 32'(q.size() == 0));
            check("m_almost_full", 32'(bus.almost_full), 32'(q.size() >= AF));
            check("m_almost_empty", 32'(bus.almost_empty), 32'(q.size() <= AE));
            check("m_rd_valid", 32'(bus.rd_valid), 32'(m_rv));
            check("m_dout", 32'(bus.dout), 32'(m_dout));
            check("m_overflow", 32'(bus.overflow), 32'(m_ovf));
            check("m_underflow", 32'(bus.underflow), 32'(m_udf));
        end
    end

    // Drive one cycle's inputs, let the edge happen, return at the following negedge.
    task automatic cycle(input logic rs, input logic w, input logic r, input logic [WIDTH-1:0] d);
        rst        = rs;
        bus.w_en   = w;
        bus.r_en   = r;
        bus.din    = d;
        @(posedge clk);
        @(negedge clk);
        rst        = 1'b0;
        bus.w_en   = 1'b0;
        bus.r_en   = 1'b0;
    endtask

    task automatic wr(input logic [WIDTH-1:0] d); cycle(1'b0, 1'b1, 1'b0, d); endtask
    task automatic rd();                          cycle(1'b0, 1'b0, 1'b1, '0); endtask
    task automatic idle();                        cycle(1'b0, 1'b0, 1'b0, '0); endtask

    initial begin
        bus.w_en = 1'b0;
        bus.r_en = 1'b0;
        bus.din  = '0;
        @(negedge clk);
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        chk_en = 1'b1;
        idle();
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_almost_empty", 32'(bus.almost_empty), 1);
        check("rst_count", 32'(bus.count), 0);
        check("rst_full", 32'(bus.full), 0);
        check("rst_dout", 32'(bus.dout), 0);
        check("rst_rd_valid", 32'(bus.rd_valid), 0);
        check("rst_overflow", 32'(bus.overflow), 0);
        check("rst_underflow", 32'(bus.underflow), 0);

        // Fill 0x01..0x10, watching threshold crossings.
        for (int i = 1; i <= 16; i++) begin
            wr(8'(i));
            check("fill_count", 32'(bus.count), 32'(i));
            if (i == 2)  check("ae_at_2", 32'(bus.almost_empty), 1);
            if (i == 3)  check("ae_at_3", 32'(bus.almost_empty), 0);
            if (i == 13) check("af_at_13", 32'(bus.almost_full), 0);
            if (i == 14) check("af_at_14", 32'(bus.almost_full), 1);
            if (i == 15) check("full_at_15", 32'(bus.full), 0);
            if (i == 16) check("full_at_16", 32'(bus.full), 1);
        end
        wr(8'hFF);
        check("ovf_pulse", 32'(bus.overflow), 1);
        check("ovf_count", 32'(bus.count), 16);
        idle();
        check("ovf_clear", 32'(bus.overflow), 0);

        // Drain back-to-back.
        for (int i = 1; i <= 16; i++) begin
            rd();
            check("drain_dout", 32'(bus.dout), 32'(i));
            check("drain_rv", 32'(bus.rd_valid), 1);
        end
        check("drain_empty", 32'(bus.empty), 1);
        rd();
        check("udf_pulse", 32'(bus.underflow), 1);
        check("udf_dout_hold", 32'(bus.dout), 32'h10);
        check("udf_rv", 32'(bus.rd_valid), 0);
        idle();
        check("udf_clear", 32'(bus.underflow), 0);

        // Move pointers to 10, then fill across the wrap.
        for (int i = 0; i < 10; i++) wr(8'(8'h30 + i));
        for (int i = 0; i < 10; i++) begin
            rd();
            check("pre_wrap_dout", 32'(bus.dout), 32'(8'h30 + i));
        end
        for (int i = 0; i < 16; i++) wr(8'(8'hA0 + i));
        check("wrap_full", 32'(bus.full), 1);
        for (int i = 0; i < 16; i++) begin
            rd();
            check("wrap_dout", 32'(bus.dout), 32'(8'hA0 + i));
        end

        // Full FIFO with simultaneous write and read.
        for (int i = 0; i < 16; i++) wr(8'(8'h50 + i));
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 8'(8'hC0 + i));
            check("fullrw_count", 32'(bus.count), 16);
            check("fullrw_ovf", 32'(bus.overflow), 0);
            check("fullrw_dout", 32'(bus.dout), 32'(8'h50 + i));
        end
        for (int i = 0; i < 16; i++) begin
            rd();
            if (i < 12) check("fullrw_drain", 32'(bus.dout), 32'(8'h54 + i));
            else        check("fullrw_drain_tail", 32'(bus.dout), 32'(8'hC0 + i - 12));
        end

        // Simultaneous write/read on empty: write lands, read is rejected.
        cycle(1'b0, 1'b1, 1'b1, 8'h77);
        check("emptyrw_count", 32'(bus.count), 1);
        check("emptyrw_udf", 32'(bus.underflow), 1);
        check("emptyrw_rv", 32'(bus.rd_valid), 0);
        rd();
        check("emptyrw_dout", 32'(bus.dout), 32'h77);

        // Reset mid-operation overrides a write on the same edge.
        for (int i = 0; i < 5; i++) wr(8'(8'h60 + i));
        cycle(1'b1, 1'b1, 1'b0, 8'hEE);
        check("midrst_count", 32'(bus.count), 0);
        check("midrst_empty", 32'(bus.empty), 1);
        rd();
        check("midrst_udf", 32'(bus.underflow), 1);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/fifo_flags.md
Name: fifo_flags

Overview:
- Parametrised synchronous single-clock FIFO; next generation of the team's basic 8-bit FIFO.
- Adds configurable width and depth, fill-level count, programmable almost-full/almost-empty thresholds, registered read-valid, and overflow/underflow error pulses.
- Sits between producer and consumer stages in one clock domain; used wherever a bare full/empty FIFO gave no back-pressure margin or error visibility.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of 2, >=2.
- AF_THRESH, 14, almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- w_en  in  1  write request.
- r_en  in  1  read request.
- din  in  WIDTH  write data, sampled on an accepted write.
- dout  out  WIDTH  read data.
- rd_valid  out  1  dout carries a freshly read word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset: rst is synchronous and active-high; clock port is clk. While rst is high at a rising edge: wr_ptr=rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, dout=0, rd_valid=0, overflow=0, underflow=0. Memory contents are not reset. rst overrides w_en/r_en on the same edge; reset mid-operation discards all stored data.
- Storage: DEPTH x WIDTH array; log2(DEPTH)-bit wr_ptr/rd_ptr wrap naturally from DEPTH-1 to 0.
- Write accept: w_acc = w_en & (~full | r_acc). Accepted: mem[wr_ptr] <= din, wr_ptr+1.
- Read accept: r_acc = r_en & ~empty. Accepted: rd_ptr+1.
- Simultaneous w_en & r_en:
  - Full: both accepted; count unchanged; full stays 1.
  - Empty: write accepted, read rejected, underflow pulses; count becomes 1.
  - Otherwise: both accepted; count unchanged.
- count: +1 on w_acc only, -1 on r_acc only, unchanged on both or neither.
- Flags: registered, derived from the next count value. They are valid in the cycle after the accepting edge, together with count.
- Rejected operations:
  - w_en & ~w_acc: data dropped, pointers and count unchanged, overflow=1 for exactly one cycle.
  - r_en & empty: underflow=1 for exactly one cycle; dout holds its prior value; rd_valid=0.
- Read latency (standard mode): on r_acc at edge N, dout = mem[rd_ptr] and rd_valid=1 after edge N. rd_valid drops after the next edge with no r_acc; dout holds.
- Sustained read: back-to-back r_en gives one word per cycle; no bubbles while not empty.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - dout continuously shows mem[rd_ptr]; rd_valid = ~empty combinationally.
  - r_en pops the shown word; the next word appears after the same edge.
  - A write to an empty FIFO becomes visible on dout one cycle after the write edge.
  - dout is don't-care while empty.
- Undefined: standard one-cycle registered read latency as specified in Behaviour.
- All other behaviour (flags, count, overflow/underflow) is identical in both modes.

Test Plan:
- Reset then idle -> empty=1, almost_empty=1, count=0, full=0, dout=0, rd_valid=0, no error pulses.
- Write 16 words 0x01..0x10 with default params -> count steps 1..16; almost_empty clears at count 3; almost_full sets at 14; full sets at 16. A 17th write of 0xFF -> overflow pulses one cycle; count stays 16.
- Read 16 back-to-back from full -> dout 0x01..0x10 in order, rd_valid high 16 cycles, empty=1 at end. One more read -> underflow pulses one cycle, dout holds 0x10, rd_valid=0.
- Wrap-around: write/read 10 words, then write 16 words 0xA0..0xAF and read all -> exact order preserved across pointer wrap, full reached at 16.
- Full with w_en & r_en for 4 cycles (din 0xC0..0xC3) -> count stays 16, no overflow, reads return the oldest words. Later drain yields 0xC0..0xC3 last.
- Write 5 words, assert rst for 1 cycle with w_en=1 -> count=0, empty=1, write ignored. A subsequent read -> underflow.
